// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two memory requesters, the arbiter and the
// byte-serial memory controller. The arbiter uses the master view; the requester/controller side uses slave.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        ls_req;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_op;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic        mc_req;
  logic        mc_fetch;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [3:0]  mc_op;
  logic        mc_done;
  logic [31:0] mc_rdata;

  modport master (
    input  if_req, if_addr,
    input  ls_req, ls_addr, ls_wdata, ls_op,
    input  mc_done, mc_rdata,
    output if_done, if_data,
    output ls_done, ls_rdata,
    output mc_req, mc_fetch, mc_addr, mc_wdata, mc_op
  );

  modport slave (
    output if_req, if_addr,
    output ls_req, ls_addr, ls_wdata, ls_op,
    output mc_done, mc_rdata,
    input  if_done, if_data,
    input  ls_done, ls_rdata,
    input  mc_req, mc_fetch, mc_addr, mc_wdata, mc_op
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loads/stores beat fetches, a streak counter bounds fetch
// starvation, blocked IO stores step aside, and flushed fetch/load results are dropped.
module mem_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 4,
  parameter logic [31:0] IO_BASE       = 32'h0003_0000
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush,
  input  logic          io_buffer_full,
  mem_arbiter_if.master bus
);

  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_nx;
  logic                cancel;
  logic                cancel_nx;

  logic        mc_req_nx;
  logic        mc_fetch_nx;
  logic [31:0] mc_addr_nx;
  logic [31:0] mc_wdata_nx;
  logic [3:0]  mc_op_nx;
  logic        if_done_nx;
  logic [31:0] if_data_nx;
  logic        ls_done_nx;
  logic [31:0] ls_rdata_nx;

  logic ls_cand;
  logic grant_ls;
  logic grant_if;
  logic store_in_flight;
  logic discard;

  // An IO store facing a full output buffer is not a candidate, so it never blocks fetches.
  assign ls_cand  = bus.ls_req &&
                    !(bus.ls_op[3] && (bus.ls_addr >= IO_BASE) && io_buffer_full);
  assign grant_ls = ls_cand && !(bus.if_req && (streak == STREAK_MAX));
  assign grant_if = bus.if_req && !grant_ls;

  // Stores are already committed, so a flush never cancels them; a flush coinciding
  // with mc_done still counts as in flight.
  assign store_in_flight = !bus.mc_fetch && bus.mc_op[3];
  assign discard         = cancel || (flush && !store_in_flight);

  always_comb begin
    state_nx    = state;
    streak_nx   = streak;
    cancel_nx   = cancel;
    mc_req_nx   = bus.mc_req;
    mc_fetch_nx = bus.mc_fetch;
    mc_addr_nx  = bus.mc_addr;
    mc_wdata_nx = bus.mc_wdata;
    mc_op_nx    = bus.mc_op;
    if_done_nx  = 1'b0;
    if_data_nx  = bus.if_data;
    ls_done_nx  = 1'b0;
    ls_rdata_nx = bus.ls_rdata;

    case (state)
      IDLE: begin
        if (grant_ls) begin
          mc_req_nx   = 1'b1;
          mc_fetch_nx = 1'b0;
          mc_addr_nx  = bus.ls_addr;
          mc_wdata_nx = bus.ls_wdata;
          mc_op_nx    = bus.ls_op;
          state_nx    = BUSY;
        end else if (grant_if) begin
          mc_req_nx   = 1'b1;
          mc_fetch_nx = 1'b1;
          mc_addr_nx  = bus.if_addr;
          mc_wdata_nx = 32'h0;
          mc_op_nx    = 4'b0010;
          state_nx    = BUSY;
        end

        if (!bus.if_req || grant_if) begin
          streak_nx = '0;
        end else if (grant_ls && (streak != STREAK_MAX)) begin
          streak_nx = streak + STREAK_W'(1);
        end
      end

      BUSY: begin
        if (bus.mc_done) begin
          mc_req_nx = 1'b0;
          cancel_nx = 1'b0;
          state_nx  = RESP;
          if (!discard) begin
            if (bus.mc_fetch) begin
              if_done_nx = 1'b1;
              if_data_nx = bus.mc_rdata;
            end else begin
              ls_done_nx  = 1'b1;
              ls_rdata_nx = bus.mc_rdata;
            end
          end
        end else if (flush && !store_in_flight) begin
          cancel_nx = 1'b1;
        end
      end

      RESP: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Every output is a register; rdy_in low freezes the whole block, reset overrides it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      streak       <= '0;
      cancel       <= 1'b0;
      bus.mc_req   <= 1'b0;
      bus.mc_fetch <= 1'b0;
      bus.mc_addr  <= 32'h0;
      bus.mc_wdata <= 32'h0;
      bus.mc_op    <= 4'h0;
      bus.if_done  <= 1'b0;
      bus.if_data  <= 32'h0;
      bus.ls_done  <= 1'b0;
      bus.ls_rdata <= 32'h0;
    end else if (rdy_in) begin
      state        <= state_nx;
      streak       <= streak_nx;
      cancel       <= cancel_nx;
      bus.mc_req   <= mc_req_nx;
      bus.mc_fetch <= mc_fetch_nx;
      bus.mc_addr  <= mc_addr_nx;
      bus.mc_wdata <= mc_wdata_nx;
      bus.mc_op    <= mc_op_nx;
      bus.if_done  <= if_done_nx;
      bus.if_data  <= if_data_nx;
      bus.ls_done  <= ls_done_nx;
      bus.ls_rdata <= ls_rdata_nx;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the two memory requesters and the byte-serial memory controller: the instruction-fetch path (ICache miss) and the load/store buffer.
- Grants the single memory port to one requester at a time and latches that request. Drives one transaction downstream, then returns data and a done pulse to the winner.
- Loads/stores have priority over fetches. A streak counter stops fetch starvation.
- Also handles two side conditions: IO-store back-pressure (io_buffer_full) and pipeline flush.

Parameters:
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF waits before IF is forced in.
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO-mapped.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  ready; when low, all state and outputs hold
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch word address
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction word
- ls_req  in  1  load/store request, level, held until ls_done
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data
- ls_op  in  4  [1:0] width 0/1/2 = byte/half/word; [2] unsigned; [3] store
- ls_done  out  1  one-cycle pulse; ls_rdata valid for loads
- ls_rdata  out  32  load result (extended by the memory controller)
- flush  in  1  pipeline flush (mispredict), one-cycle pulse
- io_buffer_full  in  1  IO output buffer full
- mc_req  out  1  transaction request to the memory controller, level
- mc_fetch  out  1  1 = instruction fetch, 0 = load/store
- mc_addr  out  32  latched address
- mc_wdata  out  32  latched store data
- mc_op  out  4  latched op; 4'b0010 for fetch
- mc_done  in  1  one-cycle completion pulse from the memory controller
- mc_rdata  in  32  returned word, valid with mc_done

Behaviour:
- Reset: state=IDLE, streak=0, cancel=0. All outputs are 0.
- All outputs are registered. The rdy_in=0 freeze has precedence below reset only.
- States: IDLE, BUSY, RESP.
- IDLE, winner selection:
  - Candidate LS = ls_req && !(ls_op[3] && ls_addr>=IO_BASE && io_buffer_full).
  - Candidate IF = if_req.
  - If both are candidates: IF wins when streak==MAX_LS_STREAK, else LS wins.
  - On a grant: latch addr/wdata/op into mc_*, set mc_fetch, mc_req<=1, go to BUSY.
  - On an LS grant with if_req high: streak<=streak+1 (saturating).
  - On an IF grant: streak<=0. If if_req is low: streak<=0.
  - No candidate: stay in IDLE, mc_req=0.
  - A blocked IO store never stalls fetches; IF may be granted in its place.
- BUSY:
  - mc_req stays 1 and mc_* stay stable until mc_done.
  - On mc_done: mc_req<=0, go to RESP.
  - If cancel==0: pulse the winner's done and drive its data from mc_rdata.
  - If cancel==1: no done pulse; cancel<=0.
- RESP: exactly one cycle, then IDLE. Requests are ignored in this cycle so a requester that drops req after seeing done is never re-granted.
- Latency: req sampled in IDLE at cycle t → mc_req=1 at t+1. mc_done at d → done=1 at d+1 → IDLE at d+2. Minimum back-to-back grant spacing is 3 cycles plus memory time.
- Flush:
  - In IDLE or RESP: no effect on the arbiter. Requesters drop their own reqs.
  - In BUSY with a fetch or a load in flight: cancel<=1. The transaction runs to completion on the bus because the memory controller cannot abort. Its result is discarded.
  - In BUSY with a store in flight: ignored. The store completes and ls_done pulses (stores are committed).
  - flush in the same cycle as mc_done: counts as in-flight, so the result is discarded.
- Done pulses: if_done and ls_done are never high together. Each is high for exactly one cycle.
- mc_done received in IDLE or RESP is ignored.
- Synchronous reset mid-transaction: returns to IDLE immediately with mc_req=0. The memory controller is reset by the same rst_in.

Test Plan:
- IF only: if_req=1, if_addr=0x100; mc_done at t+6 with mc_rdata=0x00500093 → mc_req at t+1, mc_fetch=1, mc_op=4'b0010; if_done=1 and if_data=0x00500093 at t+7; IDLE at t+8.
- Priority: if_req and ls_req (load word 0x200) both high in IDLE → LS granted first (mc_fetch=0, mc_addr=0x200); IF granted after ls_done plus RESP.
- Starvation: if_req held high; 5 back-to-back loads → first 4 granted to LS; 5th grant goes to IF; streak reads 0 after the IF grant.
- IO back-pressure: store to 0x30000, io_buffer_full=1, if_req=1 → IF granted and store stalled; io_buffer_full→0 → store granted next IDLE with mc_op[3]=1.
- Flush: fetch in BUSY, flush pulse, then mc_done → no if_done, returns to IDLE. Repeat with a store in flight → ls_done still pulses.
- rdy_in=0 for 3 cycles in BUSY with mc_done low → mc_* and state unchanged. rst_in in BUSY → next cycle all outputs 0, IDLE.
